m_sequencer: RTL

- FSM controller for the M-extension multiply/divide datapath register block.
- Accepts one RV32M operation at a time, selected by funct3, and drives that block's mux selects (mux_A, mux_B, mux_R, mux_D, mux_Z) plus result_signed, cycle by cycle.
- Multiplies use the DSP path; divides use 32-step restoring division.
- Tells the writeback mux which register/transform forms rd, and raises a one-cycle done pulse.

---
 rtl/m_sequencer_if.sv | 69 ++++++
 rtl/m_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/m_sequencer_if.sv
// Mux-select code definitions for the M-extension datapath, plus the interface that bundles
// the sequencer's request, status and datapath-select signals.
//
// Ports carried by m_sequencer_if:
//   start, funct3, rs1, rs2, sub_neg  : request and datapath status (master -> slave)
//   busy, done, result_sel            : sequencer status to writeback (slave -> master)
//   mux_A, mux_B, mux_R, mux_D, mux_Z : datapath register selects (slave -> master)
//   result_signed                     : signed upper-product extraction (slave -> master)

`ifndef M_DEFINITIONS_SVH
`define M_DEFINITIONS_SVH

`define MUX_A_LENGTH      2
`define MUX_A_KEEP        2'd0
`define MUX_A_R_UNSIGNED  2'd1
`define MUX_A_R_SIGNED    2'd2

`define MUX_B_LENGTH      2
`define MUX_B_KEEP        2'd0
`define MUX_B_D_UNSIGNED  2'd1
`define MUX_B_D_SIGNED    2'd2

`define MUX_R_LENGTH      3
`define MUX_R_KEEP        3'd0
`define MUX_R_A           3'd1
`define MUX_R_A_NEG       3'd2
`define MUX_R_SUB_KEEP    3'd3
`define MUX_R_MULT_LOWER  3'd4

`define MUX_D_LENGTH      2
`define MUX_D_KEEP        2'd0
`define MUX_D_B           2'd1
`define MUX_D_B_NEG       2'd2
`define MUX_D_SHR         2'd3

`define MUX_Z_LENGTH      2
`define MUX_Z_KEEP        2'd0
`define MUX_Z_ZERO        2'd1
`define MUX_Z_SHL_ADD     2'd2
`define MUX_Z_MULT_UPPER  2'd3

`endif

interface m_sequencer_if;
  logic                      start;
  logic [2:0]                funct3;
  logic [31:0]               rs1;
  logic [31:0]               rs2;
  logic                      sub_neg;
  logic                      busy;
  logic                      done;
  logic [2:0]                result_sel;
  logic [`MUX_A_LENGTH-1:0]  mux_A;
  logic [`MUX_B_LENGTH-1:0]  mux_B;
  logic [`MUX_R_LENGTH-1:0]  mux_R;
  logic [`MUX_D_LENGTH-1:0]  mux_D;
  logic [`MUX_Z_LENGTH-1:0]  mux_Z;
  logic                      result_signed;

  modport master (
    output start, funct3, rs1, rs2, sub_neg,
    input  busy, done, result_sel, mux_A, mux_B, mux_R, mux_D, mux_Z, result_signed
  );

  modport slave (
    input  start, funct3, rs1, rs2, sub_neg,
    output busy, done, result_sel, mux_A, mux_B, mux_R, mux_D, mux_Z, result_signed
  );
endinterface

// File: rtl/m_sequencer.sv
// Sequencer for the RV32M multiply/divide datapath. Accepts one operation at a time, drives
// the datapath mux selects each cycle, and pulses done with a writeback transform selector.
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : m_sequencer_if.slave (request in, status and mux selects out)
//
// Multiplies: load -> MOPS -> MWAIT (MUL_LAT cycles) -> MCAP -> DONE.
// Divides:    load -> DIV_IT (DIV_STEPS cycles) -> DONE; divide-by-zero and signed overflow
//             skip straight to DONE.

module m_sequencer #(
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned DIV_STEPS = 32
) (
  input logic           clk,
  input logic           reset,
  m_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StMops,
    StMwait,
    StMcap,
    StDivIt,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SpNone,
    SpDiv0,
    SpOvf
  } special_e;

  state_e     state_q, state_d;
  special_e   special_q, special_d;
  logic [2:0] op_q, op_d;
  logic       quot_neg_q, quot_neg_d;
  logic       rem_neg_q, rem_neg_d;
  logic [5:0] cnt_q, cnt_d;

  logic [`MUX_A_LENGTH-1:0] mux_a;
  logic [`MUX_B_LENGTH-1:0] mux_b;
  logic [`MUX_R_LENGTH-1:0] mux_r;
  logic [`MUX_D_LENGTH-1:0] mux_d;
  logic [`MUX_Z_LENGTH-1:0] mux_z;
  logic [2:0]               result_sel;
  logic                     result_signed;
  logic                     done;

  logic div_signed;
  logic op_mulh_signed;
  logic unused_sub_neg;

  // The subtractor sign is consumed inside the datapath by SUB_KEEP, not here.
  assign unused_sub_neg = bus.sub_neg;

  // DIV and REM are the signed divides (funct3 = 1x0).
  assign div_signed     = bus.funct3[2] & ~bus.funct3[0];
  assign op_mulh_signed = (op_q == 3'b001) || (op_q == 3'b010);

  always_comb begin
    state_d       = state_q;
    special_d     = special_q;
    op_d          = op_q;
    quot_neg_d    = quot_neg_q;
    rem_neg_d     = rem_neg_q;
    cnt_d         = cnt_q;
    mux_a         = `MUX_A_KEEP;
    mux_b         = `MUX_B_KEEP;
    mux_r         = `MUX_R_KEEP;
    mux_d         = `MUX_D_KEEP;
    mux_z         = `MUX_Z_KEEP;
    result_sel    = 3'd0;
    result_signed = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Load cycle: datapath registers capture the operands at this edge.
        if (bus.start && !reset) begin
          op_d  = bus.funct3;
          mux_z = `MUX_Z_ZERO;
          if (!bus.funct3[2]) begin
            mux_r      = `MUX_R_A;
            mux_d      = `MUX_D_B;
            quot_neg_d = 1'b0;
            rem_neg_d  = 1'b0;
            special_d  = SpNone;
            state_d    = StMops;
          end else begin
            mux_r      = (div_signed && bus.rs1[31]) ? `MUX_R_A_NEG : `MUX_R_A;
            mux_d      = (div_signed && bus.rs2[31]) ? `MUX_D_B_NEG : `MUX_D_B;
            quot_neg_d = div_signed & (bus.rs1[31] ^ bus.rs2[31]);
            rem_neg_d  = div_signed & bus.rs1[31];
            cnt_d      = 6'd0;
            if (bus.rs2 == 32'd0) begin
              // R keeps raw rs1 so REM/REMU by zero can return it directly.
              mux_r     = `MUX_R_A;
              special_d = SpDiv0;
              state_d   = StDone;
            end else if (div_signed && bus.rs1 == 32'h8000_0000 &&
                         bus.rs2 == 32'hFFFF_FFFF) begin
              mux_r     = `MUX_R_A;
              special_d = SpOvf;
              state_d   = StDone;
            end else begin
              special_d = SpNone;
              state_d   = StDivIt;
            end
          end
        end
      end

      StMops: begin
        mux_a   = op_mulh_signed ? `MUX_A_R_SIGNED : `MUX_A_R_UNSIGNED;
        mux_b   = (op_q == 3'b001) ? `MUX_B_D_SIGNED : `MUX_B_D_UNSIGNED;
        cnt_d   = 6'd0;
        state_d = StMwait;
      end

      StMwait: begin
        // Stays MUL_LAT cycles so the DSP product is valid in MCAP.
        if (cnt_q == 6'(MUL_LAT - 1)) begin
          state_d = StMcap;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      StMcap: begin
        mux_r         = `MUX_R_MULT_LOWER;
        mux_z         = `MUX_Z_MULT_UPPER;
        result_signed = op_mulh_signed;
        state_d       = StDone;
      end

      StDivIt: begin
        mux_r = `MUX_R_SUB_KEEP;
        mux_z = `MUX_Z_SHL_ADD;
        mux_d = `MUX_D_SHR;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_STEPS - 1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
        if (special_q == SpDiv0) begin
          result_sel = op_q[1] ? 3'd0 : 3'd4;
        end else if (special_q == SpOvf) begin
          result_sel = op_q[1] ? 3'd5 : 3'd0;
        end else if (!op_q[2]) begin
          result_sel = (op_q == 3'b000) ? 3'd0 : 3'd1;
        end else if (!op_q[1]) begin
          result_sel = quot_neg_q ? 3'd3 : 3'd1;
        end else begin
          result_sel = rem_neg_q ? 3'd2 : 3'd0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      special_q  <= SpNone;
      op_q       <= 3'd0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      cnt_q      <= 6'd0;
    end else begin
      state_q    <= state_d;
      special_q  <= special_d;
      op_q       <= op_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = done;
  assign bus.result_sel    = result_sel;
  assign bus.mux_A         = mux_a;
  assign bus.mux_B         = mux_b;
  assign bus.mux_R         = mux_r;
  assign bus.mux_D         = mux_d;
  assign bus.mux_Z         = mux_z;
  assign bus.result_signed = result_signed;

endmodule
